// File: rtl/alu_pkg.sv
// Shared definitions for the operand-fetch stage and the ALU that follows it:
// datapath widths, MIPS field positions, opcode/func codes and the fetch state enum.
package alu_pkg;

    localparam int DATA_W   = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 1 << REG_AW;

    // MIPS instruction field bit positions
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int SHAMT_MSB  = 10;
    localparam int SHAMT_LSB  = 6;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int FUNC_MSB   = 5;
    localparam int FUNC_LSB   = 0;

    // Opcodes decoded by the ALU
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    // R-type func codes decoded by the ALU
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // Occupancy of the fetch stage: nothing, output register only, output plus skid
    typedef enum logic [1:0] {
        FETCH_EMPTY = 2'd0,
        FETCH_ONE   = 2'd1,
        FETCH_FULL  = 2'd2
    } fetch_state_e;

    function automatic logic [REG_AW-1:0] getRs(input logic [DATA_W-1:0] instr);
        return instr[RS_MSB:RS_LSB];
    endfunction

    function automatic logic [REG_AW-1:0] getRt(input logic [DATA_W-1:0] instr);
        return instr[RT_MSB:RT_LSB];
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port.
// Register 0 always reads zero and silently drops writes. Reset clears every entry
// and takes priority over a write in the same cycle.
module regfile_2r1w
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] raddrA_i,
    output logic [DATA_W-1:0] rdataA_o,
    input  logic [REG_AW-1:0] raddrB_i,
    output logic [DATA_W-1:0] rdataB_o,
    input  logic              wen_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i
);

    logic [DATA_W-1:0] mem_q [NUM_REGS];

    // Clear on reset, otherwise commit a write to any register except r0
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wen_i && (waddr_i != '0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdataA_o = (raddrA_i == '0) ? '0 : mem_q[raddrA_i];
    assign rdataB_o = (raddrB_i == '0) ? '0 : mem_q[raddrB_i];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads rs/rt from the register file as an instruction is
// accepted and presents instruction/regA/regB to the ALU one cycle later.
// An output register plus a one-entry skid buffer lets in_ready be a plain flop.
// Define OPERAND_FETCH_BYPASS_EN to forward same-cycle writebacks into newly read
// operands and into operands already sitting in the output/skid registers.
module operand_fetch
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_instruction,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] instruction,
    output logic [DATA_W-1:0] regA,
    output logic [DATA_W-1:0] regB
);

    fetch_state_e      state_q, state_d;
    logic              inReady_q, inReady_d;
    logic [DATA_W-1:0] outInstr_q, outInstr_d, outA_q, outA_d, outB_q, outB_d;
    logic [DATA_W-1:0] skidInstr_q, skidInstr_d, skidA_q, skidA_d, skidB_q, skidB_d;

    logic [REG_AW-1:0] rsAddr, rtAddr;
    logic [DATA_W-1:0] rfA, rfB;
    logic [DATA_W-1:0] newA, newB, outAFwd, outBFwd, skidAFwd, skidBFwd;
    logic              accept, transfer;

    assign rsAddr = getRs(in_instruction);
    assign rtAddr = getRt(in_instruction);

    regfile_2r1w uRegfile (
        .clk      (clk),
        .reset    (reset),
        .raddrA_i (rsAddr),
        .rdataA_o (rfA),
        .raddrB_i (rtAddr),
        .rdataB_o (rfB),
        .wen_i    (wb_en),
        .waddr_i  (wb_addr),
        .wdata_i  (wb_data)
    );

`ifdef OPERAND_FETCH_BYPASS_EN
    logic wbHit;
    assign wbHit    = wb_en && (wb_addr != '0);
    assign newA     = (wbHit && (wb_addr == rsAddr))              ? wb_data : rfA;
    assign newB     = (wbHit && (wb_addr == rtAddr))              ? wb_data : rfB;
    assign outAFwd  = (wbHit && (wb_addr == getRs(outInstr_q)))  ? wb_data : outA_q;
    assign outBFwd  = (wbHit && (wb_addr == getRt(outInstr_q)))  ? wb_data : outB_q;
    assign skidAFwd = (wbHit && (wb_addr == getRs(skidInstr_q))) ? wb_data : skidA_q;
    assign skidBFwd = (wbHit && (wb_addr == getRt(skidInstr_q))) ? wb_data : skidB_q;
`else
    assign newA     = rfA;
    assign newB     = rfB;
    assign outAFwd  = outA_q;
    assign outBFwd  = outB_q;
    assign skidAFwd = skidA_q;
    assign skidBFwd = skidB_q;
`endif

    // in_ready is registered, so it is low exactly when the skid entry is occupied
    assign accept   = in_valid && inReady_q;
    assign transfer = (state_q != FETCH_EMPTY) && out_ready;

    // Next occupancy and buffer contents; held entries keep their (possibly forwarded) operands
    always_comb begin
        state_d     = state_q;
        outInstr_d  = outInstr_q;
        outA_d      = outAFwd;
        outB_d      = outBFwd;
        skidInstr_d = skidInstr_q;
        skidA_d     = skidAFwd;
        skidB_d     = skidBFwd;
        case (state_q)
            FETCH_EMPTY: begin
                if (accept) begin
                    outInstr_d = in_instruction;
                    outA_d     = newA;
                    outB_d     = newB;
                    state_d    = FETCH_ONE;
                end
            end
            FETCH_ONE: begin
                if (accept && transfer) begin
                    outInstr_d = in_instruction;
                    outA_d     = newA;
                    outB_d     = newB;
                end else if (accept) begin
                    skidInstr_d = in_instruction;
                    skidA_d     = newA;
                    skidB_d     = newB;
                    state_d     = FETCH_FULL;
                end else if (transfer) begin
                    state_d = FETCH_EMPTY;
                end
            end
            FETCH_FULL: begin
                if (transfer) begin
                    outInstr_d = skidInstr_q;
                    outA_d     = skidAFwd;
                    outB_d     = skidBFwd;
                    state_d    = FETCH_ONE;
                end
            end
            default: state_d = FETCH_EMPTY;
        endcase
        inReady_d = (state_d != FETCH_FULL);
    end

    // State and buffer registers; reset drops both entries and holds off upstream
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FETCH_EMPTY;
            inReady_q   <= 1'b0;
            outInstr_q  <= '0;
            outA_q      <= '0;
            outB_q      <= '0;
            skidInstr_q <= '0;
            skidA_q     <= '0;
            skidB_q     <= '0;
        end else begin
            state_q     <= state_d;
            inReady_q   <= inReady_d;
            outInstr_q  <= outInstr_d;
            outA_q      <= outA_d;
            outB_q      <= outB_d;
            skidInstr_q <= skidInstr_d;
            skidA_q     <= skidA_d;
            skidB_q     <= skidB_d;
        end
    end

    assign in_ready    = inReady_q;
    assign out_valid   = (state_q != FETCH_EMPTY);
    assign instruction = outInstr_q;
    assign regA        = outA_q;
    assign regB        = outB_q;

endmodule
